// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// instruction fields and the ALUOp codes handed to the ALU control decoder.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_R_EXEC   = 4'd2,
        S_R_WB     = 4'd3,
        S_I_ADD    = 4'd4,
        S_I_OR     = 4'd5,
        S_I_LUI    = 4'd6,
        S_I_WB     = 4'd7,
        S_MEM_ADDR = 4'd8,
        S_MEM_RD   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_MEM_WB   = 4'd11,
        S_BRANCH   = 4'd12,
        S_JUMP     = 4'd13,
        S_JR       = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;

    localparam logic [2:0] ALUOP_NONE  = 3'b000;
    localparam logic [2:0] ALUOP_RTYPE = 3'b111;
    localparam logic [2:0] ALUOP_ADD   = 3'b100;
    localparam logic [2:0] ALUOP_OR    = 3'b001;
    localparam logic [2:0] ALUOP_LUI   = 3'b101;
    localparam logic [2:0] ALUOP_SUB   = 3'b010;

    // ALU control decoder output selected by ALUOP_SUB.
    localparam logic [3:0] ALUCTL_SUB = 4'b0100;

    function automatic logic funct_legal(input logic [5:0] f);
        return f inside {FN_AND, FN_OR, FN_NOR, FN_ADD, FN_SUB, FN_SLL, FN_SRL, FN_JR};
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of a memory access and flags the cycle on which the
// access has waited MEM_TIMEOUT cycles and memory is still not ready.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic wait_i,
    input  logic ready_i,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A late ready on the limit cycle still completes the access.
    assign timeout_o = wait_i && !ready_i && (cnt_q == LIMIT);

    // The abort itself clears the count so a retried fetch gets a full budget.
    assign cnt_d = (wait_i && !ready_i && !timeout_o) ? cnt_q + 1'b1 : '0;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core: sequences fetch, decode,
// execute, memory and writeback over the shared ALU and memory port.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] ALUOp,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic       bus_error,
    output logic [3:0] state_dbg
);

    state_t state_q, state_d;
    logic   in_wait;
    logic   timeout;

    assign in_wait   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign state_dbg = state_q;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_wait (
        .clk      (clk),
        .reset    (reset),
        .wait_i   (in_wait),
        .ready_i  (mem_ready),
        .timeout_o(timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_d    = state_q;
        ALUOp      = ALUOP_NONE;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_source  = 2'b00;
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        bus_error  = 1'b0;

        // Outputs stay quiet in the reset cycle even if a state was mid-access.
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ALUOp     = ALUOP_ADD;
                    if (timeout) begin
                        mem_read  = 1'b0;
                        bus_error = 1'b1;
                    end else if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    ALUOp     = ALUOP_ADD;
                    case (opcode)
                        OP_RTYPE: begin
                            if (!funct_legal(funct)) begin
                                illegal_op = 1'b1;
                                state_d    = S_FETCH;
                            end else if (funct == FN_JR) begin
                                state_d = S_JR;
                            end else begin
                                state_d = S_R_EXEC;
                            end
                        end
                        OP_ADDI:        state_d = S_I_ADD;
                        OP_ORI:         state_d = S_I_OR;
                        OP_LUI:         state_d = S_I_LUI;
                        OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_J:           state_d = S_JUMP;
                        default: begin
                            illegal_op = 1'b1;
                            state_d    = S_FETCH;
                        end
                    endcase
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    ALUOp     = ALUOP_RTYPE;
                    state_d   = S_R_WB;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    state_d   = S_FETCH;
                end
                S_I_ADD, S_I_OR, S_I_LUI: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    ALUOp     = (state_q == S_I_ADD) ? ALUOP_ADD :
                                (state_q == S_I_OR)  ? ALUOP_OR  : ALUOP_LUI;
                    state_d   = S_I_WB;
                end
                S_I_WB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    ALUOp     = ALUOP_ADD;
                    state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                    if (timeout) begin
                        mem_read  = 1'b0;
                        bus_error = 1'b1;
                        state_d   = S_FETCH;
                    end else if (mem_ready) begin
                        state_d = S_MEM_WB;
                    end
                end
                S_MEM_WR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                    if (timeout) begin
                        mem_write = 1'b0;
                        bus_error = 1'b1;
                        state_d   = S_FETCH;
                    end else if (mem_ready) begin
                        state_d = S_FETCH;
                    end
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    ALUOp     = ALUOP_SUB;
                    pc_source = 2'b01;
                    pc_write  = (opcode == OP_BNE) ? !zero : zero;
                    state_d   = S_FETCH;
                end
                S_JUMP: begin
                    pc_source = 2'b10;
                    pc_write  = 1'b1;
                    state_d   = S_FETCH;
                end
                S_JR: begin
                    pc_source = 2'b11;
                    pc_write  = 1'b1;
                    state_d   = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into
// a per-cycle expectation list from its class and the memory latencies chosen.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic [2:0] ALUOp;
    logic       alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic       reg_dst, mem_to_reg, illegal_op, bus_error;
    logic [3:0] state_dbg;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .ALUOp(ALUOp), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .pc_write(pc_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .bus_error(bus_error),
        .state_dbg(state_dbg)
    );

    typedef struct {
        logic [3:0] st;
        logic       rdy;
        logic       ir_w, pc_w, reg_w, mrd, mwr, berr, ill;
        logic       chk_sel;
    } cyc_t;

    cyc_t plan[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    wire [10:0] sel_got  = {alu_src_a, alu_src_b, ALUOp, pc_source, i_or_d, reg_dst, mem_to_reg};
    wire [17:0] all_outs = {ALUOp, alu_src_a, alu_src_b, pc_source, pc_write, i_or_d, mem_read,
                            mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal_op, bus_error};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %0h want %0h", tag, cyc, got, exp);
        end
    endtask

    // {alu_src_a, alu_src_b, ALUOp, pc_source, i_or_d, reg_dst, mem_to_reg} per state
    function automatic logic [10:0] exp_sel(input logic [3:0] st);
        case (st)
            S_FETCH:    return {1'b0, 2'b01, 3'b100, 2'b00, 1'b0, 1'b0, 1'b0};
            S_DECODE:   return {1'b0, 2'b11, 3'b100, 2'b00, 1'b0, 1'b0, 1'b0};
            S_R_EXEC:   return {1'b1, 2'b00, 3'b111, 2'b00, 1'b0, 1'b0, 1'b0};
            S_R_WB:     return {1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1, 1'b0};
            S_I_ADD:    return {1'b1, 2'b10, 3'b100, 2'b00, 1'b0, 1'b0, 1'b0};
            S_I_OR:     return {1'b1, 2'b10, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0};
            S_I_LUI:    return {1'b1, 2'b10, 3'b101, 2'b00, 1'b0, 1'b0, 1'b0};
            S_MEM_ADDR: return {1'b1, 2'b10, 3'b100, 2'b00, 1'b0, 1'b0, 1'b0};
            S_MEM_RD:   return {1'b0, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0};
            S_MEM_WR:   return {1'b0, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0};
            S_MEM_WB:   return {1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1};
            S_BRANCH:   return {1'b1, 2'b00, 3'b010, 2'b01, 1'b0, 1'b0, 1'b0};
            S_JUMP:     return {1'b0, 2'b00, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0};
            S_JR:       return {1'b0, 2'b00, 3'b000, 2'b11, 1'b0, 1'b0, 1'b0};
            default:    return '0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (!(op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B})) return 1'b0;
        if (op == 6'h00 && !(fn inside {6'h24, 6'h25, 6'h27, 6'h20, 6'h22, 6'h00, 6'h02, 6'h08}))
            return 1'b0;
        return 1'b1;
    endfunction

    function automatic cyc_t mk(input logic [3:0] st);
        cyc_t c;
        c.st = st; c.rdy = 1'b1;
        c.ir_w = 1'b0; c.pc_w = 1'b0; c.reg_w = 1'b0; c.mrd = 1'b0; c.mwr = 1'b0;
        c.berr = 1'b0; c.ill = 1'b0; c.chk_sel = 1'b1;
        return c;
    endfunction

    // lat = cycles with mem_ready low before it rises; abort = ready never comes.
    task automatic push_mem(input logic [3:0] st, input int lat, input bit abort);
        int n = abort ? TO + 1 : lat + 1;
        for (int i = 0; i < n; i++) begin
            cyc_t c;
            c = mk(st);
            c.rdy = 1'b0;
            if (abort && i == n - 1) begin
                c.berr    = 1'b1;
                c.chk_sel = 1'b0;
            end else begin
                c.mrd = (st != S_MEM_WR);
                c.mwr = (st == S_MEM_WR);
            end
            if (!abort && i == n - 1) begin
                c.rdy = 1'b1;
                if (st == S_FETCH) begin c.ir_w = 1'b1; c.pc_w = 1'b1; end
            end
            plan.push_back(c);
        end
    endtask

    task automatic run_plan();
        while (plan.size() > 0) begin
            cyc_t c;
            c = plan.pop_front();
            mem_ready = c.rdy;
            @(negedge clk);
            check("state",      state_dbg,  c.st);
            check("ir_write",   ir_write,   c.ir_w);
            check("pc_write",   pc_write,   c.pc_w);
            check("reg_write",  reg_write,  c.reg_w);
            check("mem_read",   mem_read,   c.mrd);
            check("mem_write",  mem_write,  c.mwr);
            check("bus_error",  bus_error,  c.berr);
            check("illegal_op", illegal_op, c.ill);
            if (c.chk_sel) check("selects", sel_got, exp_sel(c.st));
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int lf, input bit af, input int lm, input bit am);
        cyc_t c;
        opcode = op; funct = fn; zero = z;
        if (af) push_mem(S_FETCH, 0, 1'b1);
        push_mem(S_FETCH, lf, 1'b0);
        c = mk(S_DECODE);
        c.ill = !is_legal(op, fn);
        plan.push_back(c);
        if (is_legal(op, fn)) begin
            if (op == 6'h00 && fn == 6'h08) begin
                c = mk(S_JR); c.pc_w = 1'b1; plan.push_back(c);
            end else if (op == 6'h00) begin
                plan.push_back(mk(S_R_EXEC));
                c = mk(S_R_WB); c.reg_w = 1'b1; plan.push_back(c);
            end else if (op inside {6'h08, 6'h0D, 6'h0F}) begin
                plan.push_back(mk(op == 6'h08 ? S_I_ADD : op == 6'h0D ? S_I_OR : S_I_LUI));
                c = mk(S_I_WB); c.reg_w = 1'b1; plan.push_back(c);
            end else if (op == 6'h23) begin
                plan.push_back(mk(S_MEM_ADDR));
                push_mem(S_MEM_RD, lm, am);
                if (!am) begin c = mk(S_MEM_WB); c.reg_w = 1'b1; plan.push_back(c); end
            end else if (op == 6'h2B) begin
                plan.push_back(mk(S_MEM_ADDR));
                push_mem(S_MEM_WR, lm, am);
            end else if (op == 6'h02) begin
                c = mk(S_JUMP); c.pc_w = 1'b1; plan.push_back(c);
            end else begin
                c = mk(S_BRANCH); c.pc_w = (op == 6'h04) ? z : !z; plan.push_back(c);
            end
        end
        run_plan();
    endtask

    task automatic reset_cycles(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'b1;
            opcode    = 6'($urandom_range(0, 63));
            @(negedge clk);
            check("reset outputs", all_outs, 18'd0);
            @(posedge clk);
            #1;
            cyc++;
        end
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] op, fn;
        int k, lf, lm;
        bit af, am;
        cyc_t c;
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset_cycles(2);

        do_instr(6'h00, 6'h20, 1'b0, 0, 1'b0, 0, 1'b0);   // add
        do_instr(6'h23, 6'h00, 1'b0, 0, 1'b0, 3, 1'b0);   // lw, 3 stall cycles
        do_instr(6'h04, 6'h00, 1'b1, 0, 1'b0, 0, 1'b0);   // beq taken
        do_instr(6'h04, 6'h00, 1'b0, 0, 1'b0, 0, 1'b0);   // beq not taken
        do_instr(6'h05, 6'h00, 1'b0, 0, 1'b0, 0, 1'b0);   // bne taken
        do_instr(6'h0D, 6'h00, 1'b0, 0, 1'b1, 0, 1'b0);   // fetch timeout then ori
        do_instr(6'h3F, 6'h00, 1'b0, 0, 1'b0, 0, 1'b0);   // illegal opcode
        do_instr(6'h00, 6'h3F, 1'b0, 0, 1'b0, 0, 1'b0);   // illegal funct
        do_instr(6'h2B, 6'h00, 1'b0, TO, 1'b0, TO, 1'b0); // ready exactly at the limit
        do_instr(6'h23, 6'h00, 1'b0, 1, 1'b0, 0, 1'b1);   // lw read timeout
        do_instr(6'h00, 6'h08, 1'b0, 0, 1'b0, 0, 1'b0);   // jr
        do_instr(6'h02, 6'h00, 1'b0, 2, 1'b0, 0, 1'b0);   // j

        // Reset in the middle of a stalled store.
        opcode = 6'h2B; funct = '0;
        push_mem(S_FETCH, 0, 1'b0);
        plan.push_back(mk(S_DECODE));
        plan.push_back(mk(S_MEM_ADDR));
        for (int i = 0; i < 3; i++) begin
            c = mk(S_MEM_WR); c.rdy = 1'b0; c.mwr = 1'b1; plan.push_back(c);
        end
        run_plan();
        reset_cycles(1);
        do_instr(6'h08, 6'h00, 1'b0, TO, 1'b0, 0, 1'b0);  // full wait budget after reset

        for (int n = 0; n < 250; n++) begin
            k  = $urandom_range(0, 11);
            fn = 6'h00;
            case (k)
                0: begin
                    op = 6'h00;
                    case ($urandom_range(0, 6))
                        0: fn = 6'h24; 1: fn = 6'h25; 2: fn = 6'h27; 3: fn = 6'h20;
                        4: fn = 6'h22; 5: fn = 6'h00; default: fn = 6'h02;
                    endcase
                end
                1: begin op = 6'h00; fn = 6'h08; end
                2: op = 6'h08;
                3: op = 6'h0D;
                4: op = 6'h0F;
                5: op = 6'h23;
                6: op = 6'h2B;
                7: op = 6'h04;
                8: op = 6'h05;
                9: op = 6'h02;
                10: begin
                    op = 6'h00;
                    do fn = 6'($urandom_range(0, 63)); while (is_legal(6'h00, fn));
                end
                default: begin
                    do op = 6'($urandom_range(0, 63)); while (is_legal(op, 6'h00));
                end
            endcase
            lf = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3);
            lm = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 4);
            af = ($urandom_range(0, 19) == 0);
            am = ($urandom_range(0, 14) == 0);
            do_instr(op, fn, 1'($urandom_range(0, 1)), lf, af, lm, am);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS core.
- Sequences each instruction through fetch, decode, execute, memory and writeback over one shared ALU and one shared instruction/data memory port.
- Drives the ALUOp code consumed by the ALU control decoder, the datapath mux selects and the register/PC/IR/memory enables.
- Stretches memory states on a ready handshake and aborts stalled accesses with a timeout.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles a memory state may wait for mem_ready before aborting. Legal range 1..255.
- CNT_W, 8: width of the wait counter. Must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous reset, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- ALUOp  out  3  to ALU control: 111 R-type, 100 add, 001 or, 101 lui, 010 sub
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A (jr)
- pc_write  out  1  PC load enable
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- illegal_op  out  1  one-cycle pulse on an undefined opcode or R-type funct
- bus_error  out  1  one-cycle pulse on a memory timeout
- state_dbg  out  4  current state encoding

Behaviour:
- Reset
  - Reset at a clk edge forces state FETCH and clears the wait counter.
  - While reset is high, all enables/requests, illegal_op and bus_error are 0, ALUOp = 000, and all selects are 0.
- Output decode: outputs are Moore, decoded from state, except the writes qualified by mem_ready.
- FETCH
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALUOp=100, pc_source=00.
  - While mem_ready=0: stay in FETCH.
  - On mem_ready=1: ir_write=1 and pc_write=1 in that same cycle, then go to DECODE.
- DECODE
  - Drives alu_src_a=0, alu_src_b=11, ALUOp=100 (branch target into ALUOut).
  - Next state by opcode:
    - 0x00 -> R_EXEC; if funct=0x08 -> JR instead.
    - 0x08 -> I_EXEC_ADD; 0x0D -> I_EXEC_OR; 0x0F -> I_EXEC_LUI.
    - 0x23 or 0x2B -> MEM_ADDR.
    - 0x04 / 0x05 -> BRANCH; 0x02 -> JUMP.
    - Any other opcode -> FETCH with illegal_op=1.
  - R-type funct outside {0x24, 0x25, 0x27, 0x20, 0x22, 0x00, 0x02, 0x08} also pulses illegal_op and returns to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, ALUOp=111 -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- I_EXEC_ADD / I_EXEC_OR / I_EXEC_LUI: alu_src_a=1, alu_src_b=10, ALUOp = 100 / 001 / 101 respectively -> I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUOp=100 -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, i_or_d=1; wait for mem_ready, then -> MEM_WB.
- MEM_WR: mem_write=1, i_or_d=1; wait for mem_ready, then -> FETCH.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- BRANCH
  - Drives alu_src_a=1, alu_src_b=00, ALUOp=010, pc_source=01.
  - pc_write = zero for beq, ~zero for bne.
  - -> FETCH.
- JUMP: pc_source=10, pc_write=1 -> FETCH. JR: pc_source=11, pc_write=1 -> FETCH.
- Wait counter
  - Counts cycles spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - Clears on any state change.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: pulse bus_error, drop all requests that cycle, go to FETCH.
  - The PC is not written, so the next fetch retries the same address.
- Simultaneous events:
  - mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT: the access completes and there is no bus_error.
  - reset overrides everything, including a mid-wait access. No enable is asserted in the reset cycle.
- Cycle counts, with mem_ready=1 on the first cycle: R/I-type 4, lw 5, sw 4, branch/jump 3.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encoding constants (4-bit);
  - opcode and funct constants;
  - ALUOp codes: ALUOP_RTYPE 111, ALUOP_ADD 100, ALUOP_OR 001, ALUOP_LUI 101, ALUOP_SUB 010.
- The ALU control decoder gains the entry 010 -> SUB (4'b0100) alongside this block.
- One sub-module, mem_wait_timer: counter plus timeout compare, instantiated once.

Test Plan:
- add $3,$1,$2 (opcode 0x00, funct 0x20), mem_ready tied high -> states FETCH, DECODE, R_EXEC, R_WB; ALUOp=111 in R_EXEC; reg_write=1 with reg_dst=1 in cycle 4.
- lw (0x23) with mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles; mem_to_reg=1 and reg_write=1 exactly once.
- beq (0x04) with zero=1, then with zero=0 -> pc_write=1 / 0 in BRANCH; ALUOp=010; pc_source=01.
- mem_ready held low in FETCH, MEM_TIMEOUT=16 -> bus_error pulses after 16 wait cycles; ir_write and pc_write stay 0; FETCH re-entered.
- opcode 0x3F, and R-type funct 0x3F -> illegal_op one-cycle pulse; returns to FETCH; reg_write never asserted.
- reset asserted during MEM_WR wait -> next cycle state_dbg = FETCH; mem_write=0 during and after the reset cycle.
